// File: rtl/morse_word_receiver.sv
// morse_word_receiver
// Samples a keyed Morse signal on the ce time-base tick, classifies each mark
// as dit/dah, decodes characters to ASCII and assembles whole words. Finished
// words sit in a one-word holding register behind a valid/ready handshake so
// that assembly of the next word carries on while the consumer is busy.
//
// Optional feature macro: MORSE_RX_PUNCT_EN
//   defined   -> also decode . , ? / - =
//   undefined -> those patterns decode as '*' and flag a word error
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   ce            time-base tick; all timing is counted in ce ticks
//   dit_time      nominal dit length
//   dah_time      nominal dah length
//   word_time     nominal inter-word gap length
//   tol_time      symmetric tolerance applied to all timing comparisons
//   signal        keyed input (already synchronous to clk)
//   word          packed word, first character at the LSBs, unused slots zero
//   word_len      number of valid characters in word
//   word_valid    word/word_len/word_error are valid
//   word_ready    consumer accepts on word_valid & word_ready
//   word_error    word contained a bad element, unknown pattern or truncation
//   overrun       sticky: a finished word was dropped (cleared by rst only)
//   busy          assembly FSM is not idle
module morse_word_receiver #(
  parameter int PULSE_CNT_W   = 16,
  parameter int CHAR_W        = 8,
  parameter int MAX_CHARS     = 8,
  parameter int MAX_MORSE_LEN = 6,
  parameter int LEN_W         = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic [PULSE_CNT_W-1:0]      dit_time,
  input  logic [PULSE_CNT_W-1:0]      dah_time,
  input  logic [PULSE_CNT_W-1:0]      word_time,
  input  logic [PULSE_CNT_W-1:0]      tol_time,
  input  logic                        signal,
  output logic [CHAR_W*MAX_CHARS-1:0] word,
  output logic [LEN_W-1:0]            word_len,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        word_error,
  output logic                        overrun,
  output logic                        busy
);

  localparam int ELEM_CNT_W = $clog2(MAX_MORSE_LEN + 1);
  localparam int WORD_W     = CHAR_W * MAX_CHARS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [PULSE_CNT_W-1:0]  cnt, cnt_nxt;
  logic [MAX_MORSE_LEN-1:0] elem, elem_nxt;
  logic [ELEM_CNT_W-1:0]   elem_cnt, elem_cnt_nxt;
  logic                    char_bad, char_bad_nxt;
  logic [WORD_W-1:0]       buf_word, buf_word_nxt;
  logic [LEN_W-1:0]        buf_len, buf_len_nxt;
  logic                    buf_err, buf_err_nxt;
  logic [WORD_W-1:0]       out_word, out_word_nxt;
  logic [LEN_W-1:0]        out_len, out_len_nxt;
  logic                    out_err, out_err_nxt;
  logic                    out_valid, out_valid_nxt;
  logic                    overrun_q, overrun_nxt;

  logic [PULSE_CNT_W-1:0]  char_thr, word_thr, cnt_inc;
  logic                    is_dit, is_dah, elem_val;
  logic                    do_char, do_word;
  logic [7:0]              ascii;

  // Saturating subtraction clamped to a minimum of 1, so a zero threshold
  // still needs at least one counted tick.
  function automatic logic [PULSE_CNT_W-1:0] sat_thr(input logic [PULSE_CNT_W-1:0] a,
                                                     input logic [PULSE_CNT_W-1:0] b);
    if (a > b) return a - b;
    return PULSE_CNT_W'(1);
  endfunction

  function automatic logic [PULSE_CNT_W-1:0] abs_diff(input logic [PULSE_CNT_W-1:0] a,
                                                      input logic [PULSE_CNT_W-1:0] b);
    if (a >= b) return a - b;
    return b - a;
  endfunction

  // The element register is LSB-first (first element in bit 0, 1 = dah).
  // It is folded into a code with a leading sentinel 1 followed by the
  // elements in keying order, so ".-" becomes 8'b101. Returns 0 when unknown.
  function automatic logic [7:0] decode_char(input logic [ELEM_CNT_W-1:0]    len,
                                             input logic [MAX_MORSE_LEN-1:0] pat);
    logic [7:0] code;
    code = 8'd1;
    if (int'(len) > 7) return 8'h00;
    for (int i = 0; i < MAX_MORSE_LEN; i++) begin
      if (i < int'(len)) code = {code[6:0], pat[i]};
    end
    case (code)
      8'b101:     return "A";
      8'b11000:   return "B";
      8'b11010:   return "C";
      8'b1100:    return "D";
      8'b10:      return "E";
      8'b10010:   return "F";
      8'b1110:    return "G";
      8'b10000:   return "H";
      8'b100:     return "I";
      8'b10111:   return "J";
      8'b1101:    return "K";
      8'b10100:   return "L";
      8'b111:     return "M";
      8'b110:     return "N";
      8'b1111:    return "O";
      8'b10110:   return "P";
      8'b11101:   return "Q";
      8'b1010:    return "R";
      8'b1000:    return "S";
      8'b11:      return "T";
      8'b1001:    return "U";
      8'b10001:   return "V";
      8'b1011:    return "W";
      8'b11001:   return "X";
      8'b11011:   return "Y";
      8'b11100:   return "Z";
      8'b111111:  return "0";
      8'b101111:  return "1";
      8'b100111:  return "2";
      8'b100011:  return "3";
      8'b100001:  return "4";
      8'b100000:  return "5";
      8'b110000:  return "6";
      8'b111000:  return "7";
      8'b111100:  return "8";
      8'b111110:  return "9";
`ifdef MORSE_RX_PUNCT_EN
      8'b1010101: return ".";
      8'b1110011: return ",";
      8'b1001100: return "?";
      8'b110010:  return "/";
      8'b1100001: return "-";
      8'b110001:  return "=";
`endif
      default:    return 8'h00;
    endcase
  endfunction

  assign char_thr = sat_thr(dah_time, tol_time);
  assign word_thr = sat_thr(word_time, tol_time);
  assign cnt_inc  = (cnt == {PULSE_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // All state and datapath registers; reset discards any partial or held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      elem      <= '0;
      elem_cnt  <= '0;
      char_bad  <= 1'b0;
      buf_word  <= '0;
      buf_len   <= '0;
      buf_err   <= 1'b0;
      out_word  <= '0;
      out_len   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      elem      <= elem_nxt;
      elem_cnt  <= elem_cnt_nxt;
      char_bad  <= char_bad_nxt;
      buf_word  <= buf_word_nxt;
      buf_len   <= buf_len_nxt;
      buf_err   <= buf_err_nxt;
      out_word  <= out_word_nxt;
      out_len   <= out_len_nxt;
      out_err   <= out_err_nxt;
      out_valid <= out_valid_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  // Next-state logic. The handshake runs every cycle; the FSM only moves on
  // ce ticks. Within a tick the character commit is evaluated before the word
  // commit so a word gap that also satisfies the character gap (or a
  // misconfigured word_thr <= char_thr) still flushes the last character.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    elem_nxt      = elem;
    elem_cnt_nxt  = elem_cnt;
    char_bad_nxt  = char_bad;
    buf_word_nxt  = buf_word;
    buf_len_nxt   = buf_len;
    buf_err_nxt   = buf_err;
    out_word_nxt  = out_word;
    out_len_nxt   = out_len;
    out_err_nxt   = out_err;
    out_valid_nxt = out_valid;
    overrun_nxt   = overrun_q;
    is_dit        = 1'b0;
    is_dah        = 1'b0;
    elem_val      = 1'b0;
    do_char       = 1'b0;
    do_word       = 1'b0;
    ascii         = 8'h00;

    if (out_valid && word_ready) out_valid_nxt = 1'b0;

    if (ce) begin
      case (state)
        IDLE: begin
          if (signal) begin
            state_nxt = MARK;
            cnt_nxt   = PULSE_CNT_W'(1);
          end
        end
        MARK: begin
          if (signal) begin
            cnt_nxt = cnt_inc;
          end else begin
            is_dit   = abs_diff(cnt, dit_time) <= tol_time;
            is_dah   = abs_diff(cnt, dah_time) <= tol_time;
            elem_val = !is_dit && is_dah;
            if (elem_cnt == ELEM_CNT_W'(MAX_MORSE_LEN)) begin
              char_bad_nxt = 1'b1;
            end else begin
              for (int i = 0; i < MAX_MORSE_LEN; i++) begin
                if (i == int'(elem_cnt)) elem_nxt[i] = elem_val;
              end
              elem_cnt_nxt = elem_cnt + 1'b1;
              if (!is_dit && !is_dah) char_bad_nxt = 1'b1;
            end
            state_nxt = SPACE;
            cnt_nxt   = PULSE_CNT_W'(1);
          end
        end
        SPACE: begin
          if (signal) begin
            state_nxt = MARK;
            cnt_nxt   = PULSE_CNT_W'(1);
          end else begin
            cnt_nxt = cnt_inc;
            do_word = cnt_inc >= word_thr;
            do_char = (elem_cnt != '0 || char_bad) && (cnt_inc >= char_thr || do_word);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (do_char) begin
      ascii = decode_char(elem_cnt, elem);
      if (char_bad || ascii == 8'h00) begin
        ascii       = 8'h2A;
        buf_err_nxt = 1'b1;
      end
      if (buf_len == LEN_W'(MAX_CHARS)) begin
        buf_err_nxt = 1'b1;
      end else begin
        for (int i = 0; i < MAX_CHARS; i++) begin
          if (i == int'(buf_len)) buf_word_nxt[i*CHAR_W +: CHAR_W] = CHAR_W'(ascii);
        end
        buf_len_nxt = buf_len + 1'b1;
      end
      elem_nxt     = '0;
      elem_cnt_nxt = '0;
      char_bad_nxt = 1'b0;
    end

    // The holding register may be refilled on the very cycle it is accepted.
    if (do_word) begin
      if (!out_valid || word_ready) begin
        out_word_nxt  = buf_word_nxt;
        out_len_nxt   = buf_len_nxt;
        out_err_nxt   = buf_err_nxt;
        out_valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
      buf_word_nxt = '0;
      buf_len_nxt  = '0;
      buf_err_nxt  = 1'b0;
      state_nxt    = IDLE;
    end
  end

  assign word       = out_word;
  assign word_len   = out_len;
  assign word_valid = out_valid;
  assign word_error = out_err;
  assign overrun    = overrun_q;
  assign busy       = (state != IDLE);

endmodule
